// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the frame-synchronous layer sequencer.
package layer_seq_pkg;

  typedef enum logic [2:0] {
    BOOT        = 3'd0,
    LEVEL_INTRO = 3'd1,
    PLAY        = 3'd2,
    HIT_BLINK   = 3'd3,
    DEATH       = 3'd4,
    GAME_OVER   = 3'd5
  } seq_state_t;

  localparam int SMILEY  = 0;
  localparam int BULLET  = 1;
  localparam int HOOP    = 2;
  localparam int TOWERS  = 3;
  localparam int ENEMIES = 4;
  localparam int SCORE   = 5;
  localparam int TIMER   = 6;
  localparam int LIFE    = 7;

  localparam logic [7:0] MASK_BOOT  = 8'b1 << SCORE;
  localparam logic [7:0] MASK_INTRO = (8'b1 << SCORE) | (8'b1 << TIMER) | (8'b1 << LIFE);
  localparam logic [7:0] MASK_ALL   = 8'hFF;

  // Draw enables for a state; smiley_on only matters while blinking.
  function automatic logic [7:0] layer_mask(seq_state_t s, logic smiley_on);
    logic [7:0] m;
    m = MASK_BOOT;
    case (s)
      BOOT, GAME_OVER: m = MASK_BOOT;
      LEVEL_INTRO:     m = MASK_INTRO;
      PLAY:            m = MASK_ALL;
      HIT_BLINK: begin
        m = MASK_ALL;
        m[SMILEY] = smiley_on;
      end
      DEATH:           m = 8'h00;
      default:         m = MASK_BOOT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/layer_sequencer_event_latch.sv
// Holds one game event until the next frame boundary consumes it.
module event_latch (
  input  logic clk,
  input  logic reset,
  input  logic pulse,
  input  logic consume,
  output logic taken
);

  logic pending;

  always_ff @(posedge clk) begin
    if (reset)        pending <= 1'b0;
    else if (consume) pending <= 1'b0;
    else if (pulse)   pending <= 1'b1;
  end

  // A pulse coincident with the consume cycle is seen by that consume.
  assign taken = pending | pulse;

endmodule

// File: rtl/layer_sequencer.sv
// Per-frame layer enable and override-colour controller for the VGA priority mux.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned INTRO_FRAMES = 60,
  parameter int unsigned HIT_FRAMES   = 90,
  parameter int unsigned BLINK_PERIOD = 8,
  parameter int unsigned DEATH_FRAMES = 120,
  parameter logic [7:0]  DEATH_RGB    = 8'hE0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       levelStart,
  input  logic       playerHit,
  input  logic       playerDeath,
  output logic [7:0] layerEnable,
  output logic       overrideDR,
  output logic [7:0] overrideRGB,
  output logic [2:0] seqState
);

  localparam logic [7:0] INTRO_LAST = 8'(INTRO_FRAMES - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);

  logic ls_ev, hit_ev, death_ev;

  event_latch u_ls    (.clk(clk), .reset(reset), .pulse(levelStart),  .consume(startOfFrame), .taken(ls_ev));
  event_latch u_hit   (.clk(clk), .reset(reset), .pulse(playerHit),   .consume(startOfFrame), .taken(hit_ev));
  event_latch u_death (.clk(clk), .reset(reset), .pulse(playerDeath), .consume(startOfFrame), .taken(death_ev));

  seq_state_t state, state_n;
  logic [7:0] frame_cnt, frame_n;
  logic [7:0] blink_cnt, blink_n;
  logic       smiley_on, smiley_n;

  // Next-frame decision, only evaluated on the frame boundary.
  always_comb begin
    state_n  = state;
    frame_n  = frame_cnt;
    blink_n  = blink_cnt;
    smiley_n = smiley_on;
    if (startOfFrame) begin
      case (state)
        BOOT, GAME_OVER: if (ls_ev) state_n = LEVEL_INTRO;
        LEVEL_INTRO: begin
          frame_n = frame_cnt + 8'd1;
          if (frame_cnt == INTRO_LAST) state_n = PLAY;
        end
        PLAY: begin
          if (death_ev)      state_n = DEATH;
          else if (hit_ev)   state_n = HIT_BLINK;
          else if (ls_ev)    state_n = LEVEL_INTRO;
        end
        HIT_BLINK: begin
          frame_n = frame_cnt + 8'd1;
          blink_n = blink_cnt + 8'd1;
          if (death_ev)                    state_n = DEATH;
          else if (frame_cnt == HIT_LAST)  state_n = PLAY;
          else if (blink_cnt == BLINK_LAST) begin
            smiley_n = ~smiley_on;
            blink_n  = 8'd0;
          end
        end
        DEATH: begin
          frame_n = frame_cnt + 8'd1;
          if (frame_cnt == DEATH_LAST) state_n = GAME_OVER;
        end
        default: state_n = BOOT;
      endcase
      if (state_n != state) begin
        frame_n  = 8'd0;
        blink_n  = 8'd0;
        smiley_n = (state_n != HIT_BLINK);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      frame_cnt   <= 8'd0;
      blink_cnt   <= 8'd0;
      smiley_on   <= 1'b1;
      layerEnable <= MASK_BOOT;
      overrideDR  <= 1'b0;
      overrideRGB <= 8'h00;
    end else begin
      state       <= state_n;
      frame_cnt   <= frame_n;
      blink_cnt   <= blink_n;
      smiley_on   <= smiley_n;
      layerEnable <= layer_mask(state_n, smiley_n);
      overrideDR  <= (state_n == DEATH) || (state_n == GAME_OVER);
      overrideRGB <= (state_n == DEATH) ? DEATH_RGB : 8'h00;
    end
  end

  assign seqState = state;

endmodule

// File: tb/tb_layer_sequencer.sv
// Frame-level bench for layer_sequencer: table vectors plus scoreboarded long sequences.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       levelStart = 1'b0;
  logic       playerHit = 1'b0;
  logic       playerDeath = 1'b0;
  logic [7:0] layerEnable;
  logic       overrideDR;
  logic [7:0] overrideRGB;
  logic [2:0] seqState;

  layer_sequencer dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .levelStart(levelStart), .playerHit(playerHit), .playerDeath(playerDeath),
    .layerEnable(layerEnable), .overrideDR(overrideDR),
    .overrideRGB(overrideRGB), .seqState(seqState)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] le;
    logic       odr;
    logic [7:0] rgb;
  } exp_t;

  typedef struct packed {
    logic ls;
    logic hp;
    logic pd;
    logic mid;
    exp_t e;
  } vec_t;

  localparam exp_t E_BOOT  = '{3'd0, 8'h20, 1'b0, 8'h00};
  localparam exp_t E_INTRO = '{3'd1, 8'hE0, 1'b0, 8'h00};
  localparam exp_t E_PLAY  = '{3'd2, 8'hFF, 1'b0, 8'h00};
  localparam exp_t E_BOFF  = '{3'd3, 8'hFE, 1'b0, 8'h00};
  localparam exp_t E_BON   = '{3'd3, 8'hFF, 1'b0, 8'h00};
  localparam exp_t E_DEATH = '{3'd4, 8'h00, 1'b1, 8'hE0};
  localparam exp_t E_GO    = '{3'd5, 8'h20, 1'b1, 8'h00};

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t boot_tbl[$];
  vec_t go_tbl[$];

  function automatic vec_t mk(logic ls, logic hp, logic pd, logic mid, exp_t e);
    vec_t v;
    v.ls = ls; v.hp = hp; v.pd = pd; v.mid = mid; v.e = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input exp_t e);
    n_cmp++;
    if (seqState !== e.st) begin
      n_bad++;
      $display("FAIL %s seqState got %0d expected %0d", nm, seqState, e.st);
    end
    n_cmp++;
    if (layerEnable !== e.le) begin
      n_bad++;
      $display("FAIL %s layerEnable got %h expected %h", nm, layerEnable, e.le);
    end
    n_cmp++;
    if (overrideDR !== e.odr) begin
      n_bad++;
      $display("FAIL %s overrideDR got %b expected %b", nm, overrideDR, e.odr);
    end
    n_cmp++;
    if (overrideRGB !== e.rgb) begin
      n_bad++;
      $display("FAIL %s overrideRGB got %h expected %h", nm, overrideRGB, e.rgb);
    end
  endtask

  // One 4-cycle frame. Events go on the startOfFrame cycle, or mid-frame when v.mid is set.
  task automatic apply(input string nm, input vec_t v);
    exp_t x;
    startOfFrame = 1'b1;
    if (!v.mid) begin
      levelStart = v.ls; playerHit = v.hp; playerDeath = v.pd;
    end
    sb.push_back(v.e);
    tick();
    startOfFrame = 1'b0;
    levelStart = 1'b0; playerHit = 1'b0; playerDeath = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard empty got 0 expected 1", nm);
    end else begin
      x = sb.pop_front();
      check(nm, x);
    end
    tick();
    if (v.mid) begin
      levelStart = v.ls; playerHit = v.hp; playerDeath = v.pd;
    end
    tick();
    levelStart = 1'b0; playerHit = 1'b0; playerDeath = 1'b0;
    if (v.mid) check({nm, "_midhold"}, v.e);
    tick();
  endtask

  initial begin
    boot_tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, E_BOOT));
    boot_tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, E_BOOT));
    boot_tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, E_BOOT));
    boot_tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, E_BOOT));
    boot_tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, E_INTRO));
    go_tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, E_GO));
    go_tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, E_GO));
    go_tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, E_INTRO));

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset", E_BOOT);
    for (int i = 0; i < 5; i++) apply("boot_idle", mk(1'b0, 1'b0, 1'b0, 1'b0, E_BOOT));

    foreach (boot_tbl[i]) apply("boot_tbl", boot_tbl[i]);
    for (int k = 1; k < 60; k++)
      apply("intro", mk(1'b0, k == 10, k == 20, 1'b0, E_INTRO));
    apply("intro_to_play", mk(1'b0, 1'b0, 1'b0, 1'b0, E_PLAY));

    // Hit in PLAY, with a retrigger on-SOF at 20 and mid-frame at 45 that must not restart.
    apply("blink_entry", mk(1'b0, 1'b1, 1'b0, 1'b0, E_BOFF));
    for (int i = 1; i < 90; i++)
      apply("blink", mk(1'b0, (i == 20) || (i == 45), 1'b0, i == 45,
                        (((i / 8) % 2) == 0) ? E_BOFF : E_BON));
    apply("blink_to_play", mk(1'b0, 1'b0, 1'b0, 1'b0, E_PLAY));

    apply("blink2_entry", mk(1'b0, 1'b1, 1'b0, 1'b0, E_BOFF));
    apply("blink2", mk(1'b0, 1'b0, 1'b0, 1'b0, E_BOFF));
    apply("hit_and_death", mk(1'b0, 1'b1, 1'b1, 1'b0, E_DEATH));
    for (int k = 1; k < 120; k++)
      apply("death", mk(k == 50, 1'b0, 1'b0, 1'b0, E_DEATH));
    apply("death_to_go", mk(1'b0, 1'b0, 1'b0, 1'b0, E_GO));

    foreach (go_tbl[i]) apply("go_tbl", go_tbl[i]);
    for (int k = 1; k < 60; k++)
      apply("intro2", mk(1'b0, 1'b0, k == 30, k == 30, E_INTRO));
    apply("intro2_to_play", mk(1'b0, 1'b0, 1'b0, 1'b0, E_PLAY));

    apply("mid_death", mk(1'b0, 1'b0, 1'b1, 1'b1, E_PLAY));
    apply("mid_death_taken", mk(1'b0, 1'b0, 1'b0, 1'b0, E_DEATH));
    apply("death_b", mk(1'b0, 1'b0, 1'b0, 1'b0, E_DEATH));

    // levelStart left pending when reset hits during DEATH must be dropped.
    levelStart = 1'b1;
    tick();
    levelStart = 1'b0;
    reset = 1'b1;
    tick();
    check("reset_in_death", E_BOOT);
    reset = 1'b0;
    tick();
    apply("after_reset", mk(1'b0, 1'b0, 1'b0, 1'b0, E_BOOT));
    apply("after_reset2", mk(1'b1, 1'b0, 1'b0, 1'b0, E_INTRO));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
